// File: rtl/decode_instruction_queue.sv
// Circular instruction queue between fetch and the format decoder.
// Each accepted fetch is stamped with a unique major ID and presented on registered outputs.
module decode_instruction_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int queueDepth              = 8,
    parameter int queueIndexWidth         = 3
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               fetchValid_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    output logic                               fetchStall_o,
    input  logic                               stall_i,
    output logic                               enable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o
);
    localparam logic [queueIndexWidth:0]           FULL_COUNT = (queueIndexWidth+1)'(queueDepth);
    localparam logic [queueIndexWidth:0]           CNT_ONE    = (queueIndexWidth+1)'(1);
    localparam logic [queueIndexWidth-1:0]         PTR_ONE    = queueIndexWidth'(1);
    localparam logic [instructionCounterWidth-1:0] ID_ONE     = instructionCounterWidth'(1);

    logic [instructionWidth-1:0]        entry_instr_q [queueDepth];
    logic [addressWidth-1:0]            entry_addr_q  [queueDepth];
    logic [PidSize-1:0]                 entry_pid_q   [queueDepth];
    logic [TidSize-1:0]                 entry_tid_q   [queueDepth];
    logic [instructionCounterWidth-1:0] entry_id_q    [queueDepth];

    logic [queueIndexWidth-1:0]         head_q, head_d;
    logic [queueIndexWidth-1:0]         tail_q, tail_d;
    logic [queueIndexWidth:0]           count_q, count_d;
    logic [instructionCounterWidth-1:0] maj_id_q, maj_id_d;
    logic                               enable_q, enable_d;
    logic [instructionWidth-1:0]        out_instr_q, out_instr_d;
    logic [addressWidth-1:0]            out_addr_q, out_addr_d;
    logic [PidSize-1:0]                 out_pid_q, out_pid_d;
    logic [TidSize-1:0]                 out_tid_q, out_tid_d;
    logic [instructionCounterWidth-1:0] out_id_q, out_id_d;

    logic full;
    logic push;
    logic pop;
    logic write_en;

    // Full is judged from the pre-edge count, so a pop in the same cycle does not free a slot.
    assign full         = (count_q == FULL_COUNT);
    assign fetchStall_o = full && !reset_i;
    assign push         = fetchValid_i && !full;
    assign pop          = !stall_i && (count_q != '0);
    assign write_en     = push && !flush_i && !reset_i;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        maj_id_d    = maj_id_q;
        enable_d    = enable_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        out_pid_d   = out_pid_q;
        out_tid_d   = out_tid_q;
        out_id_d    = out_id_q;

        if (flush_i) begin
            // The major ID counter keeps running so flushed IDs are never reissued.
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            enable_d = 1'b0;
        end else begin
            if (push) begin
                tail_d   = tail_q + PTR_ONE;
                maj_id_d = maj_id_q + ID_ONE;
            end
            if (!stall_i) begin
                if (pop) begin
                    out_instr_d = entry_instr_q[head_q];
                    out_addr_d  = entry_addr_q[head_q];
                    out_pid_d   = entry_pid_q[head_q];
                    out_tid_d   = entry_tid_q[head_q];
                    out_id_d    = entry_id_q[head_q];
                    enable_d    = 1'b1;
                    head_d      = head_q + PTR_ONE;
                end else begin
                    enable_d = 1'b0;
                end
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            maj_id_q    <= '0;
            enable_q    <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            out_pid_q   <= '0;
            out_tid_q   <= '0;
            out_id_q    <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            maj_id_q    <= maj_id_d;
            enable_q    <= enable_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            out_pid_q   <= out_pid_d;
            out_tid_q   <= out_tid_d;
            out_id_q    <= out_id_d;
        end
    end

    // Queue storage carries no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clock_i) begin
        if (write_en) begin
            entry_instr_q[tail_q] <= instruction_i;
            entry_addr_q[tail_q]  <= instructionAddress_i;
            entry_pid_q[tail_q]   <= instructionPid_i;
            entry_tid_q[tail_q]   <= instructionTid_i;
            entry_id_q[tail_q]    <= maj_id_q;
        end
    end

    assign enable_o             = enable_q;
    assign instruction_o        = out_instr_q;
    assign instructionAddress_o = out_addr_q;
    assign instructionPid_o     = out_pid_q;
    assign instructionTid_o     = out_tid_q;
    assign instructionMajId_o   = out_id_q;

endmodule

// File: doc/decode_instruction_queue.md
Name: decode_instruction_queue

Overview:
- Buffering stage between fetch and the format decoder.
- Accepts fetched instructions with their address, PID and TID, and stamps each with a unique 64-bit major ID from a free-running counter.
- Holds entries in a circular FIFO and presents one entry per cycle on registered outputs to the format decoder.
- Absorbs decoder stalls and back-pressures fetch when full; supports a pipeline flush.

Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, instruction word width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- queueDepth, 8, FIFO entries; power of 2, at least 2
- queueIndexWidth, 3, log2(queueDepth)

Ports:
- clock_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- flush_i  in  1  discard all queued and presented instructions
- fetchValid_i  in  1  fetch presents an instruction this cycle
- instruction_i  in  instructionWidth  instruction word
- instructionAddress_i  in  addressWidth  instruction address
- instructionPid_i  in  PidSize  process ID
- instructionTid_i  in  TidSize  thread ID
- fetchStall_o  out  1  queue full; fetch must hold
- stall_i  in  1  format decoder cannot accept; hold outputs
- enable_o  out  1  output bundle valid
- instruction_o  out  instructionWidth
- instructionAddress_o  out  addressWidth
- instructionPid_o  out  PidSize
- instructionTid_o  out  TidSize
- instructionMajId_o  out  instructionCounterWidth  unique major ID

Behaviour:
- State:
  - head and tail pointers, queueIndexWidth bits each
  - count, queueIndexWidth+1 bits, 0..queueDepth
  - majIdCounter, instructionCounterWidth bits
  - output registers
- Priority per rising edge: reset_i > flush_i > normal operation.
- Reset sets every register to 0: head, tail, count, majIdCounter, enable_o and all data outputs.
- fetchStall_o is combinational: 1 exactly when count == queueDepth. It is 0 during and after reset.
- Push:
  - Occurs when fetchValid_i && !fetchStall_o.
  - Writes instruction, address, PID, TID and the current majIdCounter into entry[tail].
  - tail increments modulo queueDepth; majIdCounter increments.
- Rejected fetch: when full, fetchValid_i is ignored. No entry is written and majIdCounter does not advance.
- Pop (only when stall_i = 0):
  - If count > 0, entry[head] loads into the output registers, enable_o = 1, and head increments modulo queueDepth.
  - If count == 0, enable_o = 0 and data outputs hold their last values.
- stall_i = 1: all outputs, including enable_o, hold their values and no pop occurs. Pushes still proceed.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
- Full queue with a pop in the same cycle: the push is still rejected, because fetchStall_o is evaluated from the pre-edge count.
- No bypass. An instruction pushed into an empty queue at edge N appears with enable_o = 1 after edge N+1. Minimum latency is 2 cycles.
- flush_i:
  - Sets head, tail and count to 0 and clears enable_o.
  - Any push in the same cycle is discarded.
  - majIdCounter is not reset. IDs already issued are never reused.
- Wrap-around:
  - Pointers wrap from queueDepth-1 to 0.
  - majIdCounter wraps from 2^64-1 to 0.
- Ordering: strict FIFO. Major IDs on enable_o cycles are strictly consecutive between flushes, except where a flush drops entries (gaps are allowed).

Test Plan:
- Reset, then push instruction 0x38000001 at addr 0x1000 with PID 3, TID 7 for one cycle, stall_i=0 -> two edges later: enable_o=1, instruction_o=0x38000001, addr 0x1000, PID 3, TID 7, MajId 0. The next cycle enable_o=0.
- stall_i=1, push 8 consecutive instructions -> fetchStall_o=1 after the 8th. A 9th fetchValid_i is ignored. Release stall_i -> 8 outputs on consecutive cycles with MajIds 0..7, then fetchStall_o=0.
- Full queue with stall_i=0 and fetchValid_i held high -> the first cycle's push is rejected, pushes resume the next cycle, and no MajId is skipped.
- Stream 20 instructions with stall_i toggling every 3 cycles -> output order and MajIds 0..19 are preserved. Outputs are stable during every stall cycle, and the pointers wrap correctly.
- Push 5 instructions, assert flush_i together with a 6th push -> enable_o=0 next cycle and count=0. The next push emerges with MajId 5 (the discarded 6th consumed no ID).
- Assert reset_i mid-stream with a full queue and stall_i=1 -> all outputs 0, fetchStall_o=0, and the next accepted instruction gets MajId 0.
